synch_count_ctrl: RTL and testbench
===================================

Name: synch_count_ctrl

Overview:
- Controller that sequences a WIDTH-bit synchronous up-counter through programmed count runs.
- Accepts a start/stop command pair, latches a terminal value and a prescale divider, paces counting with an internal prescaler, and signals completion with a one-cycle done pulse.
- Supports one-shot and auto-reload runs.
- Sits between the control logic and the counter datapath; it is the only agent that enables, clears or reloads the count.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESCALE_W, 4, prescale divider width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clear  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort the current run; sampled in RUN.
- limit  in  WIDTH  terminal count; latched on accepted start.
- prescale  in  PRESCALE_W  tick period minus 1; latched on accepted start.
- reload  in  1  1 = auto-reload, 0 = one-shot; latched on accepted start.
- q  out  WIDTH  current count value.
- busy  out  1  high while in RUN.
- tick  out  1  one-cycle count-enable strobe.
- done  out  1  one-cycle pulse on terminal count.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE.
  - q=0, busy=0, tick=0, done=0.
  - Prescale counter and all latched fields = 0.
  - Deassertion takes effect on the next rising clk.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1 and stop=0: latch limit, prescale and reload; q<=0; prescale counter<=0; go to RUN.
  - Otherwise hold state; q keeps its last value.
- RUN:
  - busy=1.
  - Prescale counter increments each cycle.
  - tick is combinationally high in the cycle the prescale counter equals the latched prescale. On that edge the prescale counter returns to 0.
  - tick period is prescale+1 cycles; prescale=0 gives tick every cycle.
- Count update, on the tick edge:
  - If q != latched limit: q<=q+1.
  - If q == latched limit: done<=1 for exactly one cycle. Then:
    - reload=1: q<=0, stay in RUN.
    - reload=0: q holds limit, go to FIN.
- A one-shot run therefore takes limit+1 ticks. With limit=0 the first tick terminates the run and q stays 0.
- FIN:
  - busy=0; q holds.
  - Unconditional transition to IDLE on the next cycle; start is ignored in FIN.
- stop:
  - stop=1 in RUN forces IDLE on the next edge.
  - q holds its value, no done pulse, prescale counter cleared.
  - If stop and tick coincide, stop wins: no increment, no done.
  - start=1 with stop=1 in IDLE is ignored.
- start while in RUN is ignored; latched fields are not updated mid-run.
- Arithmetic: q never wraps past the latched limit. Because q is compared against the latched limit, a wrap at 2^WIDTH-1 is not reachable.
- Asynchronous reset mid-run returns everything to reset values immediately. A done pulse in flight is lost.

Optional Feature:
- Macro: SYNCH_COUNT_CTRL_DOWN_EN.
- Defined:
  - Extra input port dir (1 bit), latched on accepted start.
  - dir=1: q loads latched limit on start, decrements on each tick, terminal value is 0. Reload reloads limit.
  - dir=0: up-count behaviour as above.
- Undefined: no dir port; up-count only.

Decomposition:
- Package synch_count_pkg:
  - state enum (IDLE, RUN, FIN).
  - default WIDTH and PRESCALE_W constants.
- Sub-module synch_prescale:
  - PRESCALE_W-bit divider with enable, synchronous restart and tick output.
  - Instantiated once; the top holds the FSM and the count register.

Test Plan:
- Reset: hold clear=0 with start=1 for 5 cycles -> q=0, busy=0, done=0, tick=0 throughout; release, then start=1, limit=3, prescale=0, reload=0 -> q sequence 0,1,2,3 on consecutive cycles, done pulse one cycle after q reaches 3 at tick, then FIN, then IDLE with q=3.
- Prescale: limit=2, prescale=3 -> tick every 4th cycle; q increments at cycles 4 and 8 after start; done at the third tick; run is 12 cycles in RUN.
- Auto-reload: limit=1, prescale=0, reload=1, run 8 cycles -> q=0,1,0,1,...; done every 2nd cycle; busy stays 1; stop=1 -> IDLE next edge, no done.
- Stop/tick collision: limit=5, prescale=1, assert stop in a tick cycle with q=2 -> q stays 2, done=0, busy=0 next cycle.
- Corner cases:
  - limit=0 -> done on the first tick, q=0.
  - start during RUN with a new limit=7 -> ignored; run ends at the original limit.
  - clear pulsed low mid-run -> immediate reset values.
- With SYNCH_COUNT_CTRL_DOWN_EN: dir=1, limit=4, prescale=0 -> q=4,3,2,1,0; done after 0; reload=1 restarts at 4.

Source files
------------

// File: rtl/synch_count_pkg.sv
// synch_count_pkg
// Shared definitions for the synch_count_ctrl slice.
//   state_t            : controller states (IDLE, RUN, FIN)
//   DEFAULT_WIDTH      : default counter width in bits
//   DEFAULT_PRESCALE_W : default prescale divider width in bits
package synch_count_pkg;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/synch_prescale.sv
// synch_prescale
// Programmable divider that paces the count. The counter runs 0..period
// and wraps, so one tick is produced every period+1 enabled cycles.
// Ports:
//   clk     in  system clock
//   clear   in  asynchronous active-low reset
//   en      in  count enable (controller is in RUN)
//   restart in  synchronous return to 0, wins over en
//   period  in  tick period minus 1
//   tick    out high in the cycle the counter equals period while enabled
module synch_prescale
  import synch_count_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // tick is combinational so the controller can act on the same edge
  // that wraps the divider back to 0.
  assign tick = en && (cnt == period);

  // Divider register: restart holds it at 0 outside of a run and on abort,
  // otherwise it counts up and wraps when it reaches the period.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == period) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/synch_count_ctrl.sv
// synch_count_ctrl
// Sequences a WIDTH-bit synchronous counter through programmed runs.
// A run is launched from IDLE by start (without stop); limit, prescale and
// reload are captured at that moment and stay fixed for the whole run.
// The count advances once per prescaler tick; reaching the terminal value
// gives a one-cycle done pulse and either reloads (auto-reload) or ends the
// run through FIN. stop aborts a run with no done pulse.
// Optional build macro SYNCH_COUNT_CTRL_DOWN_EN adds a dir input: dir=1
// loads limit on start and counts down to a terminal value of 0.
// Ports:
//   clk      in  system clock
//   clear    in  asynchronous active-low reset
//   start    in  begin a run (IDLE only)
//   stop     in  abort the current run (RUN only)
//   limit    in  terminal count
//   prescale in  tick period minus 1
//   reload   in  1 = auto-reload, 0 = one-shot
//   dir      in  1 = count down (only with SYNCH_COUNT_CTRL_DOWN_EN)
//   q        out current count
//   busy     out high while in RUN
//   tick     out count-enable strobe
//   done     out one-cycle pulse on terminal count
module synch_count_ctrl
  import synch_count_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  reload,
`ifdef SYNCH_COUNT_CTRL_DOWN_EN
  input  logic                  dir,
`endif
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  tick,
  output logic                  done
);

  state_t                state;
  logic [WIDTH-1:0]      lim;
  logic [PRESCALE_W-1:0] pre;
  logic                  rel;
  logic                  count_down;
  logic [WIDTH-1:0]      start_val;
  logic [WIDTH-1:0]      term_val;
  logic                  pre_en;
  logic                  pre_restart;
  logic                  pre_tick;

`ifdef SYNCH_COUNT_CTRL_DOWN_EN
  logic                  dir_q;

  // Direction is captured with the other run fields so a mid-run change of
  // the dir pin cannot redirect an active run.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      dir_q <= 1'b0;
    end else if (state == IDLE && start && !stop) begin
      dir_q <= dir;
    end
  end

  assign count_down = dir_q;
  assign start_val  = dir ? limit : '0;
`else
  assign count_down = 1'b0;
  assign start_val  = '0;
`endif

  // The count begins at one end of the range and terminates at the other;
  // an auto-reload restarts from the same starting end.
  assign term_val = count_down ? '0 : lim;

  // The divider only runs in RUN and is forced back to 0 whenever a run is
  // not active or is being aborted, so every run starts with a full period.
  assign pre_en      = (state == RUN);
  assign pre_restart = (state != RUN) || stop;
  assign tick        = pre_tick;

  synch_prescale #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescale (
    .clk     (clk),
    .clear   (clear),
    .en      (pre_en),
    .restart (pre_restart),
    .period  (pre),
    .tick    (pre_tick)
  );

  // Controller FSM with the count register and registered busy/done.
  // stop is checked before tick in RUN so an abort on a tick cycle neither
  // advances the count nor raises done. done defaults low every cycle,
  // which makes it a single-cycle pulse.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lim   <= '0;
      pre   <= '0;
      rel   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            lim   <= limit;
            pre   <= prescale;
            rel   <= reload;
            q     <= start_val;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pre_tick) begin
            if (q == term_val) begin
              done <= 1'b1;
              if (rel) begin
                q <= count_down ? lim : '0;
              end else begin
                busy  <= 1'b0;
                state <= FIN;
              end
            end else if (count_down) begin
              q <= q - WIDTH'(1);
            end else begin
              q <= q + WIDTH'(1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synch_count_ctrl.sv
// tb_synch_count_ctrl
// Self-checking bench for synch_count_ctrl. Expected outputs come from a
// run-level arithmetic model: elapsed cycles since the start edge give the
// number of completed ticks, from which count, busy, done and tick follow.
// Build with SYNCH_COUNT_CTRL_DOWN_EN defined to also exercise down-counting.
module tb_synch_count_ctrl;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk;
  logic          clear;
  logic          start;
  logic          stop;
  logic [W-1:0]  limit;
  logic [PW-1:0] prescale;
  logic          reload;
`ifdef SYNCH_COUNT_CTRL_DOWN_EN
  logic          dir;
`endif
  logic [W-1:0]  q;
  logic          busy;
  logic          tick;
  logic          done;

  int vectors;
  int miscompares;

  synch_count_ctrl #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .stop     (stop),
    .limit    (limit),
    .prescale (prescale),
    .reload   (reload),
`ifdef SYNCH_COUNT_CTRL_DOWN_EN
    .dir      (dir),
`endif
    .q        (q),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  // Free-running clock; stimulus and sampling both happen on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {q, busy, done, tick} k cycles after the start edge.
  // s >= 0 is the sample at which stop was held high (abort on the next edge).
  // dn selects down-counting, where the count is limit minus the up value.
  function automatic logic [W+2:0] model(input int k, input int L, input int p,
                                         input bit rel, input int s, input bit dn);
    int  per;
    int  kk;
    int  n;
    int  val;
    int  fin_k;
    logic eb;
    logic ed;
    logic et;
    per   = p + 1;
    kk    = (s >= 0 && k > s) ? s : k;
    n     = kk / per;
    fin_k = (L + 1) * per;
    if (rel) begin
      val = n % (L + 1);
      eb  = 1'b1;
      ed  = (kk > 0) && (kk % per == 0) && (n % (L + 1) == 0);
      et  = (kk % per == p);
    end else if (kk < fin_k) begin
      val = n;
      eb  = 1'b1;
      ed  = 1'b0;
      et  = (kk % per == p);
    end else begin
      val = L;
      eb  = 1'b0;
      ed  = (kk == fin_k);
      et  = 1'b0;
    end
    if (s >= 0 && k > s) begin
      eb = 1'b0;
      ed = 1'b0;
      et = 1'b0;
    end
    if (dn) val = L - val;
    return {W'(val), eb, ed, et};
  endfunction

  task automatic start_run(input int L, input int p, input bit rel);
    limit    = W'(L);
    prescale = PW'(p);
    reload   = rel;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+2:0] obs;
    clear = 1'b0;
    start = 1'b1;
    limit = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {q, busy, done, tick};
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold cyc=%0d actual=%b required=%b", i, obs, 7'b0);
      end
    end
    start = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    obs = {q, busy, done, tick};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_release actual=%b required=%b", obs, 7'b0);
    end
  endtask

  task automatic test_oneshot();
    int ls[5] = '{3, 2, 0, 0, 15};
    int ps[5] = '{0, 3, 0, 2, 0};
    int L, p;
    logic [W+2:0] obs, expv;
    for (int r = 0; r < 13; r++) begin
      if (r < 5) begin
        L = ls[r]; p = ps[r];
      end else begin
        L = int'($urandom_range(0, 15)); p = int'($urandom_range(0, 3));
      end
      start_run(L, p, 1'b0);
      for (int k = 0; k <= (L + 1) * (p + 1) + 1; k++) begin
        obs  = {q, busy, done, tick};
        expv = model(k, L, p, 1'b0, -1, 1'b0);
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("[TB] FAIL oneshot L=%0d p=%0d k=%0d actual=%b required=%b", L, p, k, obs, expv);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_autoreload();
    int ls[3] = '{1, 0, 3};
    int ps[3] = '{0, 1, 2};
    int ss[3] = '{8, 5, 20};
    int L, p, s;
    logic [W+2:0] obs, expv;
    for (int r = 0; r < 9; r++) begin
      if (r < 3) begin
        L = ls[r]; p = ps[r]; s = ss[r];
      end else begin
        L = int'($urandom_range(0, 15)); p = int'($urandom_range(0, 3));
        s = int'($urandom_range(0, 40));
      end
      start_run(L, p, 1'b1);
      for (int k = 0; k <= s + 2; k++) begin
        obs  = {q, busy, done, tick};
        expv = model(k, L, p, 1'b1, s, 1'b0);
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("[TB] FAIL autoreload L=%0d p=%0d s=%0d k=%0d actual=%b required=%b", L, p, s, k, obs, expv);
        end
        stop = (k == s);
        @(negedge clk);
      end
      stop = 1'b0;
    end
  endtask

  task automatic test_stop();
    int L, p, s;
    logic [W+2:0] obs, expv;
    for (int r = 0; r < 7; r++) begin
      if (r == 0) begin
        // stop lands on the tick cycle that would advance q from 2
        L = 5; p = 1; s = 5;
      end else begin
        L = int'($urandom_range(0, 15)); p = int'($urandom_range(0, 3));
        s = int'($urandom_range(0, (L + 1) * (p + 1) - 1));
      end
      start_run(L, p, 1'b0);
      for (int k = 0; k <= s + 2; k++) begin
        obs  = {q, busy, done, tick};
        expv = model(k, L, p, 1'b0, s, 1'b0);
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("[TB] FAIL stop L=%0d p=%0d s=%0d k=%0d actual=%b required=%b", L, p, s, k, obs, expv);
        end
        stop = (k == s);
        @(negedge clk);
      end
      stop = 1'b0;
    end
    // start together with stop in IDLE must not launch a run
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_with_stop actual busy=%b required busy=0", busy);
    end
  endtask

  task automatic test_start_during_run();
    logic [W+2:0] obs, expv;
    start_run(3, 1, 1'b0);
    for (int k = 0; k <= 9; k++) begin
      obs  = {q, busy, done, tick};
      expv = model(k, 3, 1, 1'b0, -1, 1'b0);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL start_in_run k=%0d actual=%b required=%b", k, obs, expv);
      end
      if (k == 2) begin
        limit = 4'd7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clear_midrun();
    logic [W+2:0] obs, expv;
    start_run(1, 0, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      obs  = {q, busy, done, tick};
      expv = model(k, 1, 0, 1'b1, -1, 1'b0);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL pre_clear k=%0d actual=%b required=%b", k, obs, expv);
      end
      if (k < 3) @(negedge clk);
    end
    // k=3 has q=1 on a tick, so a done pulse is due on the next edge
    #2;
    clear = 1'b0;
    #1;
    obs = {q, busy, done, tick};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("[TB] FAIL clear_async actual=%b required=%b", obs, 7'b0);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    obs = {q, busy, done, tick};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("[TB] FAIL clear_after actual=%b required=%b", obs, 7'b0);
    end
  endtask

`ifdef SYNCH_COUNT_CTRL_DOWN_EN
  task automatic test_down();
    logic [W+2:0] obs, expv;
    dir = 1'b1;
    start_run(4, 0, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      obs  = {q, busy, done, tick};
      expv = model(k, 4, 0, 1'b0, -1, 1'b1);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL down_oneshot k=%0d actual=%b required=%b", k, obs, expv);
      end
      @(negedge clk);
    end
    start_run(4, 0, 1'b1);
    for (int k = 0; k <= 14; k++) begin
      obs  = {q, busy, done, tick};
      expv = model(k, 4, 0, 1'b1, 12, 1'b1);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL down_reload k=%0d actual=%b required=%b", k, obs, expv);
      end
      stop = (k == 12);
      @(negedge clk);
    end
    stop = 1'b0;
    dir  = 1'b0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    limit       = '0;
    prescale    = '0;
    reload      = 1'b0;
`ifdef SYNCH_COUNT_CTRL_DOWN_EN
    dir         = 1'b0;
`endif
    test_reset();
    test_oneshot();
    test_autoreload();
    test_stop();
    test_start_during_run();
    test_clear_midrun();
`ifdef SYNCH_COUNT_CTRL_DOWN_EN
    test_down();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
